// File: rtl/stamp_square.sv
// Stamps one SQ x SQ sprite from the sprite ROM into the map memory at a grid cell.
// A single pipeline stage lines the map write up with the 1-cycle ROM read latency.
module stamp_square #(
  parameter int                DATA_W      = 9,
  parameter int                SQ          = 20,
  parameter int                MAP_W       = 160,
  parameter int                GRID_XMAX   = 7,
  parameter int                GRID_YMAX   = 5,
  parameter logic [DATA_W-1:0] TRANSPARENT = 9'h1FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        COUNTER_X,
  input  logic [3:0]        COUNTER_Y,
  input  logic [DATA_W-1:0] sprite_colour,
  output logic [8:0]        sprite_address,
  output logic [14:0]       map_address,
  output logic [DATA_W-1:0] map_data,
  output logic              map_wren,
  output logic              busy,
  output logic              stamp_square_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [4:0] PIX_LAST = 5'(SQ - 1);

  logic [1:0]  state;
  logic [4:0]  cx, cy;
  logic [3:0]  gx, gy;
  logic        oob;
  logic        vld_p1;
  logic [14:0] addr_p1;

  // Map address of pixel (cxi, cyi) inside grid cell (gxi, gyi); wraps at 15 bits,
  // which only happens for out-of-range cells whose writes are suppressed anyway.
  function automatic logic [14:0] pix_addr(input logic [3:0] gxi, input logic [3:0] gyi,
                                           input logic [4:0] cxi, input logic [4:0] cyi);
    logic [14:0] row, col;
    row = 15'(gyi) * 15'(SQ) + 15'(cyi);
    col = 15'(gxi) * 15'(SQ) + 15'(cxi);
    return row * 15'(MAP_W) + col;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cx             <= '0;
      cy             <= '0;
      oob            <= 1'b0;
      sprite_address <= '0;
      vld_p1         <= 1'b0;
    end else begin
      vld_p1 <= (state == RUN);
      case (state)
        IDLE: begin
          if (start) begin
            oob            <= (COUNTER_X > 4'(GRID_XMAX)) || (COUNTER_Y > 4'(GRID_YMAX));
            cx             <= '0;
            cy             <= '0;
            sprite_address <= '0;
            state          <= RUN;
          end
        end
        RUN: begin
          if (cx == PIX_LAST && cy == PIX_LAST) begin
            state <= DRAIN;
          end else if (cx == PIX_LAST) begin
            cx             <= '0;
            cy             <= cy + 5'd1;
            sprite_address <= sprite_address + 9'd1;
          end else begin
            cx             <= cx + 5'd1;
            sprite_address <= sprite_address + 9'd1;
          end
        end
        DRAIN:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data registers: grid cell latch and the p1 write address (no reset needed)
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      gx <= COUNTER_X;
      gy <= COUNTER_Y;
    end
    if (state == RUN) begin
      addr_p1 <= pix_addr(gx, gy, cx, cy);
    end
  end

  // Stage p1: ROM data arrives alongside the registered address
  assign map_address       = vld_p1 ? addr_p1 : '0;
  assign map_data          = vld_p1 ? sprite_colour : '0;
  assign map_wren          = vld_p1 && !oob && (sprite_colour != TRANSPARENT);
  assign busy              = (state == RUN) || (state == DRAIN);
  assign stamp_square_done = (state == DONE);

endmodule

// File: tb/tb_stamp_square.sv
// Directed bench for stamp_square: vector table of grid cells / ROM patterns plus
// hand sequences for held start, mid-run input changes and reset mid-operation.
module tb_stamp_square;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  cnt_x, cnt_y;
  logic [8:0]  sprite_colour;
  logic [8:0]  sprite_address;
  logic [14:0] map_address;
  logic [8:0]  map_data;
  logic        map_wren;
  logic        busy;
  logic        done;

  int rom_mode = 0;
  int checks   = 0;
  int errors   = 0;

  int nwr, first_a, last_a, first_d, last_d, done_cyc, done_cnt, busy_cnt, cyc_err;

  stamp_square dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .COUNTER_X         (cnt_x),
    .COUNTER_Y         (cnt_y),
    .sprite_colour     (sprite_colour),
    .sprite_address    (sprite_address),
    .map_address       (map_address),
    .map_data          (map_data),
    .map_wren          (map_wren),
    .busy              (busy),
    .stamp_square_done (done)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] rom_val(input int mode, input int a);
    if (mode == 0) return 9'h0A5;
    if (mode == 1) return 9'(a);
    return (a % 2 == 0) ? 9'h1FF : 9'(a);
  endfunction

  function automatic int exp_addr(input int gx, input int gy, input int p);
    return (gy * 20 + p / 20) * 160 + gx * 20 + p % 20;
  endfunction

  // Sprite ROM with one cycle of read latency
  always @(posedge clk) sprite_colour <= rom_val(rom_mode, int'(sprite_address));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Runs one stamp from the start edge (cycle 0) through cycle 402, comparing every
  // cycle against the reference timing and collecting write statistics.
  task automatic do_run(input int gx, input int gy, input int mode, input bit hold);
    bit oob;
    int exp_sa;
    bit exp_busy, exp_done, exp_wr;
    rom_mode = mode;
    nwr = 0; first_a = 0; last_a = 0; first_d = 0; last_d = 0;
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; cyc_err = 0;
    oob = (gx > 7) || (gy > 5);
    @(negedge clk);
    cnt_x = 4'(gx);
    cnt_y = 4'(gy);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int k = 1; k <= 402; k++) begin
      @(negedge clk);
      if (hold && k == 100) begin
        cnt_x = 4'd1;
        cnt_y = 4'd1;
      end
      exp_sa   = (k <= 400) ? k - 1 : 399;
      exp_busy = (k <= 401);
      exp_done = (k == 402);
      exp_wr   = (k >= 2) && (k <= 401) && !oob && (rom_val(mode, k - 2) != 9'h1FF);
      if (int'(sprite_address) != exp_sa || busy != exp_busy || done != exp_done ||
          map_wren != exp_wr) begin
        if (cyc_err < 3)
          $display("trace cycle %0d: sa=%0d busy=%0b done=%0b wren=%0b", k,
                   sprite_address, busy, done, map_wren);
        cyc_err++;
      end
      if (map_wren) begin
        nwr++;
        if (nwr == 1) begin
          first_a = int'(map_address);
          first_d = int'(map_data);
        end
        last_a = int'(map_address);
        last_d = int'(map_data);
        if (exp_wr && (int'(map_address) != exp_addr(gx, gy, k - 2) ||
                       map_data != rom_val(mode, k - 2))) begin
          if (cyc_err < 3)
            $display("trace cycle %0d: addr=%0d data=%0d", k, map_address, map_data);
          cyc_err++;
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = k;
      end
    end
  endtask

  typedef struct {
    int gx, gy, mode;
    int nwr, first_a, last_a, first_d, last_d;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 0, 0, 400, 0,     3059,  9'h0A5, 9'h0A5};
    tbl[1] = '{7, 5, 1, 400, 16140, 19199, 0,      399};
    tbl[2] = '{3, 1, 2, 200, 3261,  6319,  1,      399};
    tbl[3] = '{8, 2, 1, 0,   0,     0,     0,      0};
    tbl[4] = '{2, 3, 0, 400, 9640,  12699, 9'h0A5, 9'h0A5};
    tbl[5] = '{0, 6, 1, 0,   0,     0,     0,      0};

    reset = 1'b1;
    start = 1'b0;
    cnt_x = '0;
    cnt_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_wren", int'(map_wren), 0);
    check("reset_sprite_address", int'(sprite_address), 0);
    check("reset_map_address", int'(map_address), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_run(tbl[i].gx, tbl[i].gy, tbl[i].mode, 1'b0);
      check($sformatf("v%0d_writes", i), nwr, tbl[i].nwr);
      check($sformatf("v%0d_first_addr", i), first_a, tbl[i].first_a);
      check($sformatf("v%0d_last_addr", i), last_a, tbl[i].last_a);
      check($sformatf("v%0d_first_data", i), first_d, tbl[i].first_d);
      check($sformatf("v%0d_last_data", i), last_d, tbl[i].last_d);
      check($sformatf("v%0d_done_cycle", i), done_cyc, 402);
      check($sformatf("v%0d_done_count", i), done_cnt, 1);
      check($sformatf("v%0d_busy_cycles", i), busy_cnt, 401);
      check($sformatf("v%0d_cycle_trace", i), cyc_err, 0);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_idle_busy", i), int'(busy), 0);
    end

    // start held high and grid inputs changed mid-run
    do_run(4, 2, 1, 1'b1);
    check("hold_writes", nwr, 400);
    check("hold_first_addr", first_a, 6480);
    check("hold_last_addr", last_a, 9539);
    check("hold_done_count", done_cnt, 1);
    check("hold_cycle_trace", cyc_err, 0);
    @(negedge clk);
    check("hold_c403_busy", int'(busy), 0);
    check("hold_c403_done", int'(done), 0);
    @(negedge clk);
    check("hold_c404_busy", int'(busy), 1);
    check("hold_c404_sprite_address", int'(sprite_address), 0);
    start = 1'b0;
    @(negedge clk);
    check("hold_rerun_wren", int'(map_wren), 1);
    check("hold_rerun_addr", int'(map_address), 3220);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // reset sampled at the end of cycle 200 of a run
    rom_mode = 0;
    @(negedge clk);
    cnt_x = 4'd3;
    cnt_y = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (200) @(negedge clk);
    check("rst_pre_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_wren", int'(map_wren), 0);
    check("rst_done", int'(done), 0);
    check("rst_sprite_address", int'(sprite_address), 0);
    reset = 1'b0;
    done_cnt = 0;
    nwr = 0;
    for (int k = 0; k < 410; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (map_wren || busy) nwr++;
    end
    check("rst_no_done", done_cnt, 0);
    check("rst_no_activity", nwr, 0);

    do_run(1, 4, 1, 1'b0);
    check("post_rst_writes", nwr, 400);
    check("post_rst_first_addr", first_a, 12820);
    check("post_rst_last_addr", last_a, 15879);
    check("post_rst_done_cycle", done_cyc, 402);
    check("post_rst_cycle_trace", cyc_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
